// File: rtl/delay_line_ctrl_if.sv
// Request/response bundle between a client and delay_line_ctrl.
// The client (master) issues req/op/addr/wdata; the controller (slave)
// answers with busy, a one-cycle done pulse and the last word read.
interface delay_line_ctrl_if #(
  parameter int AW         = 4,
  parameter int WORD_WIDTH = 36
);
  logic                  req;
  logic [1:0]            op;
  logic [AW-1:0]         addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [WORD_WIDTH-1:0] rdata;

  modport master (
    output req, op, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  req, op, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Word-access controller for one serial recirculating delay line.
// A free-running bit counter tracks which logical bit sits at the line
// output; reads shift the addressed word out of the line into a parallel
// register, writes gate new bits into the line, clear holds the line's
// clear input low for one full revolution. Every line-facing output and
// the done/busy status come straight from flops.
module delay_line_ctrl #(
  parameter int STORE_LEN  = 16,
  parameter int WORD_WIDTH = 36,
  parameter int AW         = (STORE_LEN > 1) ? $clog2(STORE_LEN) : 1,
  localparam int N         = STORE_LEN * WORD_WIDTH,
  localparam int CW        = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  delay_line_ctrl_if.slave  bus,
  output logic [CW-1:0]     bit_cnt,
  output logic              dl_data_in,
  output logic              dl_data_in_gate,
  output logic              dl_data_clr,
  input  logic              dl_data_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_XFER  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]    OP_READ     = 2'b00;
  localparam logic [1:0]    OP_WRITE    = 2'b01;
  localparam logic [1:0]    OP_CLEAR    = 2'b10;
  localparam logic [1:0]    OP_RSVD     = 2'b11;
  localparam logic [CW-1:0] CNT_LAST    = CW'(N - 1);
  localparam logic [CW-1:0] WORD_LAST   = CW'(WORD_WIDTH - 1);
  localparam logic [31:0]   STORE_LEN_W = 32'(STORE_LEN);
  localparam logic [31:0]   WORD_W      = 32'(WORD_WIDTH);

  // Logical index of bit 0 of word a in the counter's frame.
  function automatic logic [CW-1:0] word_base(input logic [AW-1:0] a);
    return CW'(32'(a) * WORD_W);
  endfunction

  state_t                state_r, state_s;
  logic [CW-1:0]         bit_cnt_r, bit_cnt_inc_s;
  logic [1:0]            op_r, op_s;
  logic [CW-1:0]         base_r, base_s;
  logic [WORD_WIDTH-1:0] wdata_r, wdata_s;
  logic [CW-1:0]         clr_cnt_r, clr_cnt_s;
  logic [WORD_WIDTH-1:0] shadow_r, shadow_s;
  logic [WORD_WIDTH-1:0] rdata_r, rdata_s;
  logic [WORD_WIDTH-1:0] bit_mask_s;
  logic [CW-1:0]         off_now_s, off_next_s;
  logic                  xfer_now_s, xfer_last_s, xfer_next_s;
  logic                  addr_ok_s;
  logic                  gate_s, din_s;
  logic                  gate_r, din_r, clr_n_r, busy_r, done_r;

  // Counter value after the coming edge, wrapping N-1 -> 0.
  always_comb begin
    if (bit_cnt_r == CNT_LAST) begin
      bit_cnt_inc_s = '0;
    end else begin
      bit_cnt_inc_s = bit_cnt_r + CW'(1'b1);
    end
  end

  // Free-running bit-position counter locked to the line's recirculation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= '0;
    end else begin
      bit_cnt_r <= bit_cnt_inc_s;
    end
  end

  // Is the coming edge a transfer edge, and is it the last one of the word.
  // WAIT only starts the transfer when the counter sits exactly on the word
  // base, so a request accepted mid-window waits a full revolution.
  always_comb begin
    off_now_s   = bit_cnt_r - base_r;
    xfer_now_s  = (state_r == ST_XFER) ||
                  ((state_r == ST_WAIT) && (bit_cnt_r == base_r));
    xfer_last_s = xfer_now_s && (off_now_s == WORD_LAST);
    addr_ok_s   = (32'(bus.addr) < STORE_LEN_W);
  end

  // Next-state and request-context logic.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    base_s    = base_r;
    wdata_s   = wdata_r;
    clr_cnt_s = clr_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req) begin
          op_s      = bus.op;
          base_s    = word_base(bus.addr);
          wdata_s   = bus.wdata;
          clr_cnt_s = '0;
          if (bus.op == OP_CLEAR) begin
            state_s = ST_CLEAR;
          end else if ((bus.op == OP_RSVD) || !addr_ok_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (xfer_last_s) begin
          state_s = ST_DONE;
        end else if (xfer_now_s) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_XFER: begin
        if (xfer_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          clr_cnt_s = clr_cnt_r + CW'(1'b1);
          state_s   = ST_CLEAR;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Read path: merge the line output into the shadow word on transfer edges
  // and publish the completed word together with the done pulse.
  always_comb begin
    bit_mask_s = WORD_WIDTH'(1'b1) << off_now_s;
    shadow_s   = shadow_r;
    rdata_s    = rdata_r;
    if (xfer_now_s && (op_r == OP_READ)) begin
      if (dl_data_out) begin
        shadow_s = shadow_r | bit_mask_s;
      end else begin
        shadow_s = shadow_r & ~bit_mask_s;
      end
    end else begin
      shadow_s = shadow_r;
    end
    if (xfer_last_s && (op_r == OP_READ)) begin
      rdata_s = shadow_s;
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Write path: look one cycle ahead so the gate and data flops are already
  // valid during every cycle whose following edge is a transfer edge.
  always_comb begin
    off_next_s  = bit_cnt_inc_s - base_s;
    xfer_next_s = (state_s == ST_XFER) ||
                  ((state_s == ST_WAIT) && (bit_cnt_inc_s == base_s));
    if (xfer_next_s && (op_s == OP_WRITE)) begin
      gate_s = 1'b1;
      din_s  = |(wdata_s & (WORD_WIDTH'(1'b1) << off_next_s));
    end else begin
      gate_s = 1'b0;
      din_s  = 1'b0;
    end
  end

  // FSM state and latched request context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_READ;
      base_r    <= '0;
      wdata_r   <= '0;
      clr_cnt_r <= '0;
      shadow_r  <= '0;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      base_r    <= base_s;
      wdata_r   <= wdata_s;
      clr_cnt_r <= clr_cnt_s;
      shadow_r  <= shadow_s;
    end
  end

  // Registered outputs so the line and the client see glitch-free signals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r  <= 1'b0;
      din_r   <= 1'b0;
      clr_n_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      gate_r  <= gate_s;
      din_r   <= din_s;
      clr_n_r <= (state_s != ST_CLEAR);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      rdata_r <= rdata_s;
    end
  end

  assign bit_cnt         = bit_cnt_r;
  assign dl_data_in      = din_r;
  assign dl_data_in_gate = gate_r;
  assign dl_data_clr     = clr_n_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.rdata       = rdata_r;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: a behavioural serial delay line, a directed
// vector table, hand-written corner sequences and randomized operations
// checked against a word-level store model.
module tb_delay_line_ctrl;
  localparam int STORE_LEN = 16;
  localparam int WW        = 36;
  localparam int AW        = 5;
  localparam int N         = STORE_LEN * WW;
  localparam int CW        = $clog2(N);
  localparam int LAT_BOUND = N + WW + 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] bit_cnt;
  logic          dl_data_in, dl_data_in_gate, dl_data_clr;
  logic          dl_data_out = 1'b0;

  delay_line_ctrl_if #(.AW(AW), .WORD_WIDTH(WW)) bus ();

  delay_line_ctrl #(.STORE_LEN(STORE_LEN), .WORD_WIDTH(WW), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .bit_cnt        (bit_cnt),
    .dl_data_in     (dl_data_in),
    .dl_data_in_gate(dl_data_in_gate),
    .dl_data_clr    (dl_data_clr),
    .dl_data_out    (dl_data_out)
  );

  always #5 clk = ~clk;

  // Serial line: one bit recirculates or is replaced per rising edge.
  logic [N-1:0] line_r = '0;
  int           line_ptr = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_ptr <= 0;
    end else begin
      if (!dl_data_clr) line_r[line_ptr] <= 1'b0;
      else if (dl_data_in_gate) line_r[line_ptr] <= dl_data_in;
      line_ptr <= (line_ptr == N - 1) ? 0 : line_ptr + 1;
    end
  end
  always @(negedge clk) dl_data_out <= line_r[line_ptr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Word-level reference store.
  logic [WW-1:0] words_m [STORE_LEN];
  logic [WW-1:0] last_rd_m;

  typedef struct {
    logic [1:0]    op;
    int            addr;
    logic [WW-1:0] wdata;
    int            c;
    int            lat;
    int            gates;
    int            gfirst;
    int            clrs;
    logic [WW-1:0] rdata;
  } vec_t;
  vec_t vecs [12];

  task automatic wait_cnt(input int c);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((int'(bit_cnt) != c) && (guard < N + 4)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= N + 4) check("wait_cnt_timeout", 64'(bit_cnt), 64'(c));
  endtask

  task automatic watch_no_done(input string nm, input int cycles);
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) dones++;
      if (bus.busy !== 1'b0) busys++;
    end
    check({nm, "_extra_done"}, 64'(dones), 64'd0);
    check({nm, "_extra_busy"}, 64'(busys), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op_i, input int addr_i,
                        input logic [WW-1:0] wd_i, input int c_i, input int exp_lat,
                        input int exp_gates, input int exp_gfirst, input int exp_clrs,
                        input logic [WW-1:0] exp_rdata, input int pulse_at,
                        input bit req_in_done);
    int n, gates, clrs, gfirst;
    bit busy_ok, pulsing;
    logic [WW-1:0] rd_at_done;
    wait_cnt(c_i);
    bus.req = 1'b1; bus.op = op_i; bus.addr = AW'(addr_i); bus.wdata = wd_i;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.wdata = ~wd_i;
    n = 1; gates = 0; clrs = 0; gfirst = -1; busy_ok = 1'b1; pulsing = 1'b0;
    while (1'b1) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (dl_data_in_gate === 1'b1) begin
        if (gfirst < 0) gfirst = int'(bit_cnt);
        gates++;
      end
      if (dl_data_clr === 1'b0) clrs++;
      if ((bus.done === 1'b1) || (n >= LAT_BOUND)) break;
      if (n == pulse_at) begin
        bus.req = 1'b1;
        pulsing = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (pulsing) begin
        bus.req = 1'b0;
        pulsing = 1'b0;
      end
    end
    rd_at_done = bus.rdata;
    if (req_in_done) begin
      bus.req = 1'b1; bus.op = 2'b11;
    end
    @(posedge clk); #1;
    bus.req = 1'b0; bus.op = 2'b00;
    check({nm, "_latency"}, 64'(n), 64'(exp_lat));
    check({nm, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({nm, "_gate_cycles"}, 64'(gates), 64'(exp_gates));
    if (exp_gates > 0) check({nm, "_gate_first_bit"}, 64'(gfirst), 64'(exp_gfirst));
    check({nm, "_clr_cycles"}, 64'(clrs), 64'(exp_clrs));
    check({nm, "_rdata"}, 64'(rd_at_done), 64'(exp_rdata));
    check({nm, "_idle_after"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  // Derive expectations from the word store and the latency rule, then run.
  task automatic model_op(input string nm, input logic [1:0] op_i, input int a,
                          input logic [WW-1:0] wd, input int c, input int pulse_at,
                          input bit rid);
    int b, k, lat, gates, gfirst, clrs;
    logic [WW-1:0] er;
    er = last_rd_m; gates = 0; gfirst = -1; clrs = 0; lat = 1;
    if (op_i == 2'b10) begin
      lat = N + 1;
      clrs = N;
      for (int i = 0; i < STORE_LEN; i++) words_m[i] = '0;
    end else if ((op_i == 2'b11) || (a >= STORE_LEN)) begin
      lat = 1;
    end else begin
      b = a * WW;
      k = (((b - c - 1) % N) + N) % N + 1;
      lat = k + WW;
      if (op_i == 2'b01) begin
        gates = WW;
        gfirst = b;
        words_m[a] = wd;
      end else begin
        er = words_m[a];
        last_rd_m = er;
      end
    end
    run_op(nm, op_i, a, wd, c, lat, gates, gfirst, clrs, er, pulse_at, rid);
  endtask

  initial begin
    logic [63:0] rnd;
    int r, a, c, g;
    logic [1:0] op;

    bus.req = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.wdata = '0;

    // Reset values and counter start.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    check("rst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_dl_outs", {61'd0, dl_data_in, dl_data_in_gate, dl_data_clr}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_bit_cnt0", 64'(bit_cnt), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rel_bit_cnt%0d", i), 64'(bit_cnt), 64'(i));
    end

    // Directed vectors: op, addr, wdata, issue bit_cnt, latency, gate cycles,
    // first gated bit, clear cycles, rdata at done.
    vecs[0]  = '{2'b01,  3, 36'h9_2345_6789,   0, 144, 36, 108,   0, 36'h0};
    vecs[1]  = '{2'b00,  3, 36'h0,           107,  37,  0,  -1,   0, 36'h9_2345_6789};
    vecs[2]  = '{2'b00,  3, 36'h0,           108, 612,  0,  -1,   0, 36'h9_2345_6789};
    vecs[3]  = '{2'b01,  0, 36'hF_FFFF_FFFF,  10, 602, 36,   0,   0, 36'h9_2345_6789};
    vecs[4]  = '{2'b01, 15, 36'hF_FFFF_FFFF, 500,  76, 36, 540,   0, 36'h9_2345_6789};
    vecs[5]  = '{2'b00,  0, 36'h0,           575,  37,  0,  -1,   0, 36'hF_FFFF_FFFF};
    vecs[6]  = '{2'b10,  0, 36'h0,             3, 577,  0,  -1, 576, 36'hF_FFFF_FFFF};
    vecs[7]  = '{2'b00,  0, 36'h0,           575,  37,  0,  -1,   0, 36'h0};
    vecs[8]  = '{2'b00, 15, 36'h0,           539,  37,  0,  -1,   0, 36'h0};
    vecs[9]  = '{2'b11,  2, 36'h5_5555_5555,  50,   1,  0,  -1,   0, 36'h0};
    vecs[10] = '{2'b00, 16, 36'h0,           200,   1,  0,  -1,   0, 36'h0};
    vecs[11] = '{2'b01, 16, 36'h1_2345_0000, 300,   1,  0,  -1,   0, 36'h0};
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].c,
             vecs[i].lat, vecs[i].gates, vecs[i].gfirst, vecs[i].clrs, vecs[i].rdata,
             -1, 1'b0);
    end

    // Line now holds all zeros; last word read was zero.
    for (int i = 0; i < STORE_LEN; i++) words_m[i] = '0;
    last_rd_m = '0;

    // Requests while busy and in the done cycle are dropped.
    model_op("wr5", 2'b01, 5, 36'hA_BCDE_F012, 100, -1, 1'b0);
    model_op("rd5_ignore", 2'b00, 5, 36'h0, 100, 20, 1'b1);
    watch_no_done("rd5_ignore", 40);

    // Randomized operations against the word store.
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 42) ? 2'b00 : (r < 84) ? 2'b01 : (r < 92) ? 2'b10 : 2'b11;
      a = (op == 2'b10) ? $urandom_range(0, STORE_LEN - 1) : $urandom_range(0, 19);
      rnd = {$urandom, $urandom};
      c = $urandom_range(0, N - 1);
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : -1;
      model_op($sformatf("rnd%0d", i), op, a, rnd[WW-1:0], c, g, 1'($urandom_range(0, 1)));
    end

    // Reset during the 10th gated cycle of a write.
    wait_cnt(71);
    bus.req = 1'b1; bus.op = 2'b01; bus.addr = AW'(2); bus.wdata = 36'hA_5A5A_5A5A;
    @(posedge clk); #1;
    bus.req = 1'b0;
    g = 0;
    for (int i = 0; i < 100; i++) begin
      if (dl_data_in_gate === 1'b1) g++;
      if (g == 10) break;
      @(posedge clk); #1;
    end
    check("midrst_gate_count", 64'(g), 64'd10);
    check("midrst_bit_cnt", 64'(bit_cnt), 64'd81);
    rst_n = 1'b0;
    #1;
    check("midrst_gate", 64'(dl_data_in_gate), 64'd0);
    check("midrst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("midrst_bit_cnt0", 64'(bit_cnt), 64'd0);
    check("midrst_din_clr", {62'd0, dl_data_in, dl_data_clr}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("midrst", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
